// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared types and helpers for the code decoder path
package dec_pkg;

  localparam int CODE_W = 2;
  localparam int LINES  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [LINES-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [LINES-1:0] r;
    r       = '0;
    r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational 2-to-4 one-hot decoder
module onehot_dec
  import dec_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [LINES-1:0]  lines
);

  assign lines = onehot(code);

endmodule

// File: rtl/code_decoder.sv
// rtl/code_decoder.sv - holds a decoded one-hot pattern for HOLD cycles and counts events
// Optional DEC_ACTIVE_LOW_EN drives the one-hot lines inverted for active-low LEDs.
module code_decoder
  import dec_pkg::*;
#(
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [LINES-1:0]  out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  evt_cnt
);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [LINES-1:0] OUT_IDLE = '1;
`else
  localparam logic [LINES-1:0] OUT_IDLE = '0;
`endif
  localparam logic [7:0]       HOLD_M1  = 8'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic [LINES-1:0]  dec_lines, out_nx;
  logic              out_valid_nx;
  logic [CNT_W-1:0]  evt_nx;
  logic              accept;

  onehot_dec u_dec (
    .code  (in_code),
    .lines (dec_lines)
  );

  // Ready depends only on registered state, never on in_valid
  assign in_ready = (state == ST_IDLE) || (cnt == 8'd0);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      out       <= OUT_IDLE;
      out_valid <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      out       <= out_nx;
      out_valid <= out_valid_nx;
      evt_cnt   <= evt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_HOLD;
      ST_HOLD: if ((cnt == 8'd0) && !accept) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_nx       = cnt;
    out_nx       = out;
    out_valid_nx = out_valid;
    evt_nx       = evt_cnt;
    if (accept) begin
      // XOR with the idle value applies the active-low inversion at the register
      cnt_nx       = HOLD_M1;
      out_nx       = dec_lines ^ OUT_IDLE;
      out_valid_nx = 1'b1;
      if (evt_cnt != CNT_MAX) evt_nx = evt_cnt + CNT_W'(1);
    end else if (state == ST_HOLD) begin
      if (cnt != 8'd0) begin
        cnt_nx = cnt - 8'd1;
      end else begin
        out_nx       = OUT_IDLE;
        out_valid_nx = 1'b0;
      end
    end
  end

endmodule
